// File: rtl/l1i_refill_bridge_if.sv
// Port bundles for l1i_refill_bridge: the cache-side line-fill port and the
// AXI read address/data channels toward the M0 port.
interface l1i_fill_if;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        fill_valid;
  logic        fill_wait;
  logic        fill_done;
  logic        fill_err;

  modport master (
    output fill_req, fill_addr,
    input  fill_data, fill_valid, fill_wait, fill_done, fill_err
  );
  modport slave (
    input  fill_req, fill_addr,
    output fill_data, fill_valid, fill_wait, fill_done, fill_err
  );
endinterface

interface l1i_axi_rd_if;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M;
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M;
  logic        RVALID_M;
  logic        RREADY_M;

  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
    input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
  );
  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
    output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
  );
endinterface

// File: rtl/l1i_refill_bridge.sv
// L1I line-fill responder: one 4-beat INCR AXI read per miss, each beat returned
// as a one-cycle fill_valid pulse. Define L1I_REFILL_PERF_EN to build the perf counters.
module l1i_refill_bridge (
  input  logic         clk,
  input  logic         rst,
  l1i_fill_if.slave    fill,
  l1i_axi_rd_if.master axi,
  output logic [31:0]  refill_cnt,
  output logic [31:0]  stall_cnt
);

  localparam logic [3:0] ARID_VAL = 4'd0;
  localparam int         BEATS    = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e      state_q;
  logic        armed_q;
  logic        err_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [1:0]  beat_q;
  logic [31:0] araddr_q;
  logic [31:0] fill_data_q;
  logic        fill_valid_q;
  logic        fill_done_q;
  logic        fill_err_q;

  logic accept_d;
  logic ar_hs_d;
  logic r_hs_d;
  logic last_beat_d;
  logic beat_err_d;

  always_comb begin
    accept_d    = (state_q == IDLE) && fill.fill_req && armed_q;
    ar_hs_d     = arvalid_q && axi.ARREADY_M;
    r_hs_d      = rready_q && axi.RVALID_M;
    last_beat_d = (beat_q == 2'(BEATS - 1));
    // RLAST only feeds error detection; the burst always ends on the beat count.
    beat_err_d  = (axi.RRESP_M != 2'b00) || (axi.RLAST_M != last_beat_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      armed_q      <= 1'b1;
      err_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      beat_q       <= 2'd0;
      araddr_q     <= 32'd0;
      fill_data_q  <= 32'd0;
      fill_valid_q <= 1'b0;
      fill_done_q  <= 1'b0;
      fill_err_q   <= 1'b0;
    end else begin
      fill_valid_q <= 1'b0;
      fill_done_q  <= 1'b0;
      fill_err_q   <= 1'b0;
      // A held request must drop for a cycle before it can start another burst.
      if (!fill.fill_req) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q   <= ADDR;
            araddr_q  <= {fill.fill_addr[31:4], 4'b0000};
            arvalid_q <= 1'b1;
            armed_q   <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        ADDR: begin
          if (ar_hs_d) begin
            state_q   <= DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= 2'd0;
          end
        end
        DATA: begin
          if (r_hs_d) begin
            fill_data_q  <= axi.RDATA_M;
            fill_valid_q <= 1'b1;
            beat_q       <= beat_q + 2'd1;
            err_q        <= err_q | beat_err_d;
            if (last_beat_d) begin
              state_q     <= IDLE;
              rready_q    <= 1'b0;
              fill_done_q <= 1'b1;
              fill_err_q  <= err_q | beat_err_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fill.fill_data  = fill_data_q;
  assign fill.fill_valid = fill_valid_q;
  assign fill.fill_done  = fill_done_q;
  assign fill.fill_err   = fill_err_q;
  assign fill.fill_wait  = (state_q != IDLE);

  assign axi.ARID_M    = ARID_VAL;
  assign axi.ARADDR_M  = araddr_q;
  assign axi.ARLEN_M   = 4'(BEATS - 1);
  assign axi.ARSIZE_M  = 3'b010;
  assign axi.ARBURST_M = 2'b01;
  assign axi.ARVALID_M = arvalid_q;
  assign axi.RREADY_M  = rready_q;

  // Read ID and the line-offset address bits carry no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{axi.RID_M, fill.fill_addr[3:0]};

`ifdef L1I_REFILL_PERF_EN
  logic [31:0] refill_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      refill_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      if (fill_done_q)       refill_cnt_q <= refill_cnt_q + 32'd1;
      if (state_q != IDLE)   stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign refill_cnt = refill_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  assign refill_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_l1i_refill_bridge.sv
// Self-checking bench for l1i_refill_bridge: transaction-level reference model,
// per-cycle comparison, directed scenarios and a randomized soak.
module tb_l1i_refill_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] refill_cnt;
  logic [31:0] stall_cnt;

  l1i_fill_if   fif();
  l1i_axi_rd_if aif();

  l1i_refill_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .fill       (fif.slave),
    .axi        (aif.master),
    .refill_cnt (refill_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

`ifdef L1I_REFILL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: phase 0 = no fill, 1 = address offered, 2 = collecting beats.
  int          m_phase;
  int          m_beats;
  logic        m_err;
  logic        m_armed;
  logic [31:0] m_addr;
  logic [31:0] m_refill;
  logic [31:0] m_stall;
  logic        e_valid;
  logic        e_done;
  logic        e_err;
  logic [31:0] e_data;

  // Memory responder knobs.
  int ar_pct;
  int ar_delay;
  int r_mode;
  int rv_pct;
  int resp_err_beat;
  int last_err_beat;
  bit data_mode;
  bit rand_err;
  bit r_tog;

  // Event log.
  int          vcyc[$];
  logic [31:0] vdat[$];
  int          done_cnt;
  int          done_cyc;
  logic        done_err;
  int          ar_hs;
  int          arv_cycles;
  bit          addr_bad;
  logic [31:0] addr_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_beats  = 0;
    m_err    = 1'b0;
    m_armed  = 1'b1;
    m_addr   = 32'd0;
    m_refill = 32'd0;
    m_stall  = 32'd0;
    e_valid  = 1'b0;
    e_done   = 1'b0;
    e_err    = 1'b0;
    e_data   = 32'd0;
  endtask

  task automatic compare_cycle();
    chk("arvalid",    32'(aif.ARVALID_M),  32'(m_phase == 1));
    chk("rready",     32'(aif.RREADY_M),   32'(m_phase == 2));
    chk("fill_wait",  32'(fif.fill_wait),  32'(m_phase != 0));
    chk("araddr",     aif.ARADDR_M,        m_addr);
    chk("fill_valid", 32'(fif.fill_valid), 32'(e_valid));
    chk("fill_done",  32'(fif.fill_done),  32'(e_done));
    chk("fill_err",   32'(fif.fill_err),   32'(e_err));
    if (e_valid) chk("fill_data", fif.fill_data, e_data);
    chk("arid",    32'(aif.ARID_M),    32'd0);
    chk("arlen",   32'(aif.ARLEN_M),   32'd3);
    chk("arsize",  32'(aif.ARSIZE_M),  32'd2);
    chk("arburst", 32'(aif.ARBURST_M), 32'd1);
    chk("refill_cnt", refill_cnt, PERF ? m_refill : 32'd0);
    chk("stall_cnt",  stall_cnt,  PERF ? m_stall  : 32'd0);
  endtask

  task automatic log_events();
    if (fif.fill_valid) begin
      vcyc.push_back(cyc);
      vdat.push_back(fif.fill_data);
    end
    if (fif.fill_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = fif.fill_err;
    end
    if (aif.ARVALID_M) begin
      if (arv_cycles == 0) addr_first = aif.ARADDR_M;
      else if (aif.ARADDR_M !== addr_first) addr_bad = 1'b1;
      arv_cycles++;
      if (aif.ARREADY_M) ar_hs++;
    end
  endtask

  // Advance the model across the coming clock edge using this cycle's inputs.
  task automatic model_advance();
    logic nv, nd, ne;
    if (rst) begin
      model_reset();
      return;
    end
    m_refill = m_refill + 32'(e_done);
    m_stall  = m_stall + 32'(m_phase != 0);
    nv = 1'b0;
    nd = 1'b0;
    ne = 1'b0;
    if (m_phase == 0) begin
      if (fif.fill_req && m_armed) begin
        m_phase = 1;
        m_addr  = fif.fill_addr & 32'hFFFF_FFF0;
        m_err   = 1'b0;
        m_armed = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (aif.ARREADY_M) begin
        m_phase = 2;
        m_beats = 0;
      end
    end else if (aif.RVALID_M) begin
      nv     = 1'b1;
      e_data = aif.RDATA_M;
      if (aif.RRESP_M != 2'b00 || aif.RLAST_M != (m_beats == 3)) m_err = 1'b1;
      m_beats++;
      if (m_beats == 4) begin
        m_phase = 0;
        nd      = 1'b1;
        ne      = m_err;
      end
    end
    if (!fif.fill_req) m_armed = 1'b1;
    e_valid = nv;
    e_done  = nd;
    e_err   = ne;
  endtask

  task automatic drive_axi();
    aif.ARREADY_M = 1'b0;
    aif.RVALID_M  = 1'b0;
    aif.RLAST_M   = 1'b0;
    aif.RRESP_M   = 2'b00;
    aif.RDATA_M   = $urandom;
    aif.RID_M     = 4'($urandom);
    if (m_phase == 1) begin
      if (ar_delay > 0) ar_delay--;
      else aif.ARREADY_M = ($urandom_range(99) < ar_pct);
    end else if (m_phase == 2) begin
      r_tog = ~r_tog;
      case (r_mode)
        0:       aif.RVALID_M = 1'b1;
        1:       aif.RVALID_M = r_tog;
        default: aif.RVALID_M = ($urandom_range(99) < rv_pct);
      endcase
      if (data_mode) aif.RDATA_M = 32'hA0 + 32'(m_beats);
      aif.RRESP_M = (m_beats == resp_err_beat) ? 2'b10 : 2'b00;
      aif.RLAST_M = (m_beats == 3) ^ (m_beats == last_err_beat);
      if (rand_err && $urandom_range(15) == 0) aif.RRESP_M = 2'($urandom_range(3));
      if (rand_err && $urandom_range(15) == 0) aif.RLAST_M = ~aif.RLAST_M;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    log_events();
    model_advance();
    @(posedge clk);
    cyc++;
    #1;
    drive_axi();
  endtask

  task automatic wait_done(input int budget, input string name);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt - start), 32'd1);
  endtask

  task automatic clear_log();
    vcyc.delete();
    vdat.delete();
    done_cnt   = 0;
    done_cyc   = 0;
    done_err   = 1'b0;
    ar_hs      = 0;
    arv_cycles = 0;
    addr_bad   = 1'b0;
    addr_first = 32'd0;
    r_tog      = 1'b0;
  endtask

  task automatic cfg_zero_wait();
    ar_pct        = 100;
    ar_delay      = 0;
    r_mode        = 0;
    rv_pct        = 100;
    resp_err_beat = -1;
    last_err_beat = -1;
    data_mode     = 1'b1;
    rand_err      = 1'b0;
  endtask

  task automatic pulse_req(input logic [31:0] addr);
    fif.fill_addr = addr;
    fif.fill_req  = 1'b1;
    step();
    fif.fill_req  = 1'b0;
    fif.fill_addr = $urandom;
  endtask

  task automatic check_four_beats(input string name);
    chk({name, "_beats"}, 32'(vcyc.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < vdat.size()) chk({name, "_data"}, vdat[i], 32'hA0 + 32'(i));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int c0;
    int n;
    rst            = 1'b1;
    fif.fill_req   = 1'b0;
    fif.fill_addr  = 32'd0;
    aif.ARREADY_M  = 1'b0;
    aif.RVALID_M   = 1'b0;
    aif.RLAST_M    = 1'b0;
    aif.RRESP_M    = 2'b00;
    aif.RDATA_M    = 32'd0;
    aif.RID_M      = 4'd0;
    cfg_zero_wait();
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state.
    step();
    chk("reset_fill_data", fif.fill_data, 32'd0);
    chk("reset_fill_wait", 32'(fif.fill_wait), 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait fill; address changes after acceptance must not matter.
    clear_log();
    c0 = cyc;
    pulse_req(32'h0000_1234);
    wait_done(20, "zw");
    check_four_beats("zw");
    for (int i = 0; i < 4; i++)
      if (i < vcyc.size()) chk("zw_valid_cycle", 32'(vcyc[i]), 32'(c0 + 3 + i));
    chk("zw_done_cycle", 32'(done_cyc), 32'(c0 + 6));
    chk("zw_err", 32'(done_err), 32'd0);
    chk("zw_araddr", addr_first, 32'h0000_1230);
    chk("zw_ar_hs", 32'(ar_hs), 32'd1);
    step();

    // Backpressure: ARREADY low 3 cycles, one-cycle gaps between beats.
    clear_log();
    ar_delay = 3;
    r_mode   = 1;
    pulse_req(32'h0000_5678);
    wait_done(40, "bp");
    check_four_beats("bp");
    chk("bp_arvalid_cycles", 32'(arv_cycles), 32'd4);
    chk("bp_addr_stable", 32'(addr_bad), 32'd0);
    chk("bp_araddr", addr_first, 32'h0000_5670);
    for (int i = 0; i < 3; i++)
      if (i + 1 < vcyc.size()) chk("bp_gap", 32'(vcyc[i + 1] - vcyc[i]), 32'd2);
    step();

    // Held request: one burst only until fill_req drops for a cycle.
    cfg_zero_wait();
    clear_log();
    fif.fill_addr = 32'h0000_2000;
    fif.fill_req  = 1'b1;
    wait_done(20, "held1");
    repeat (5) step();
    chk("held_single_ar", 32'(ar_hs), 32'd1);
    fif.fill_req = 1'b0;
    step();
    fif.fill_req = 1'b1;
    wait_done(20, "held2");
    chk("held_second_ar", 32'(ar_hs), 32'd2);
    fif.fill_req = 1'b0;
    step();

    // Error bursts, then a clean one.
    clear_log();
    resp_err_beat = 1;
    pulse_req(32'h0000_3000);
    wait_done(20, "err_resp");
    check_four_beats("err_resp");
    chk("err_resp_flag", 32'(done_err), 32'd1);
    step();
    clear_log();
    resp_err_beat = -1;
    last_err_beat = 2;
    pulse_req(32'h0000_3010);
    wait_done(20, "err_last");
    check_four_beats("err_last");
    chk("err_last_flag", 32'(done_err), 32'd1);
    step();
    clear_log();
    last_err_beat = -1;
    pulse_req(32'h0000_3020);
    wait_done(20, "clean");
    chk("clean_flag", 32'(done_err), 32'd0);
    step();

    // Reset after the second beat.
    clear_log();
    r_mode = 1;
    pulse_req(32'h0000_4000);
    n = 0;
    while (vcyc.size() < 2 && n < 20) begin
      step();
      n++;
    end
    chk("rst_mid_reached_beat2", 32'(vcyc.size() >= 2), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_fill_wait", 32'(fif.fill_wait), 32'd0);
    chk("rst_mid_arvalid", 32'(aif.ARVALID_M), 32'd0);
    chk("rst_mid_rready", 32'(aif.RREADY_M), 32'd0);
    chk("rst_mid_fill_valid", 32'(fif.fill_valid), 32'd0);
    repeat (10) step();
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);

    // Perf counters across two zero-wait fills from reset.
    cfg_zero_wait();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_log();
    pulse_req(32'h0000_6000);
    wait_done(20, "perf1");
    pulse_req(32'h0000_6040);
    wait_done(20, "perf2");
    chk("perf_refill", refill_cnt, PERF ? 32'd2 : 32'd0);
    chk("perf_stall", stall_cnt, PERF ? 32'd10 : 32'd0);
    step();

    // Randomized soak.
    clear_log();
    ar_pct    = 70;
    r_mode    = 2;
    rv_pct    = 70;
    data_mode = 1'b0;
    rand_err  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      fif.fill_req  = ($urandom_range(99) < 50);
      fif.fill_addr = $urandom;
      rst           = ($urandom_range(399) == 0);
      step();
    end
    rst          = 1'b0;
    fif.fill_req = 1'b0;
    repeat (20) step();
    chk("rand_progress", 32'(done_cnt > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1i_refill_bridge.md
# l1i_refill_bridge

Memory-side responder for the L1 instruction cache line-fill interface. It accepts a line-fill request from the cache, issues one 4-beat INCR read burst on the CPU wrapper's AXI master read channels, and returns each beat to the cache as a single-cycle data-valid pulse. It sits between the instruction cache and the M0 AXI read port inside the CPU wrapper.

## Interface
- ARID_VAL, 4'd0: constant driven on ARID_M.
- BEATS, 4: beats per line; fixed at 4 for a 128-bit line of 32-bit words.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- fill_req  in  1  line-fill request from cache, level.
- fill_addr  in  32  miss address; bits [3:0] ignored.
- fill_data  out  32  returned beat data.
- fill_valid  out  1  one-cycle pulse per returned beat.
- fill_wait  out  1  high while a fill is in progress.
- fill_done  out  1  one-cycle pulse after the last beat.
- fill_err  out  1  pulses with fill_done when the burst had an error.
- ARID_M  out  4  read address ID.
- ARADDR_M  out  32  burst start address.
- ARLEN_M  out  4  constant 4'd3.
- ARSIZE_M  out  3  constant 3'b010.
- ARBURST_M  out  2  constant 2'b01 (INCR).
- ARVALID_M  out  1  read address valid.
- ARREADY_M  in  1  read address ready.
- RID_M  in  4  read ID; ignored.
- RDATA_M  in  32  read data.
- RRESP_M  in  2  read response.
- RLAST_M  in  1  last beat.
- RVALID_M  in  1  read data valid.
- RREADY_M  out  1  read data ready.
- refill_cnt  out  32  completed fills; see Configuration.
- stall_cnt  out  32  cycles spent in ADDR or DATA; see Configuration.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE → ADDR: fill_req=1 and `armed`=1. In that cycle, latch ARADDR_M <= {fill_addr[31:4],4'b0}.
- ADDR: ARVALID_M=1. ARADDR_M stays stable until ARVALID_M && ARREADY_M. On that handshake, go to DATA and clear the 2-bit beat counter.
- DATA: RREADY_M=1. On each RVALID_M && RREADY_M:
  - register fill_data <= RDATA_M;
  - pulse fill_valid in the next cycle;
  - increment the beat counter.
- The 4th handshake (counter==3) ends the burst and the block returns to IDLE. Termination depends only on the beat count; RLAST_M does not end the burst.
- An error is recorded in a sticky per-burst flag when either condition holds:
  - RRESP_M != 2'b00 on any beat;
  - RLAST_M differs from (counter==3) on any beat.
  The flag is cleared when the block enters ADDR.
- fill_done and fill_err (flag value) are asserted one cycle after the 4th handshake, coincident with the 4th fill_valid.
- `armed` is set whenever fill_req==0 and cleared when a request is accepted. A request still held high after fill_done therefore does not start a second burst until the cache deasserts fill_req for at least one cycle.
- fill_req is ignored in ADDR and DATA. fill_addr is sampled only at acceptance.

## Timing
- Reset values:
  - all outputs 0, except ARID_M, ARLEN_M, ARSIZE_M and ARBURST_M, which are constants;
  - state IDLE, armed=1, error flag 0, counters 0.
- fill_wait = (state != IDLE). It is combinational from state and is low in the fill_done cycle.
- Minimum latency, with ARREADY_M and RVALID_M always high:
  - request accepted at cycle 0;
  - AR handshake at cycle 1;
  - R handshakes at cycles 2–5;
  - fill_valid at cycles 3–6;
  - fill_done at cycle 6.
- R beats may arrive with gaps. fill_valid is never high for two cycles unless R handshakes occurred on consecutive cycles.
- Reset asserted mid-burst returns all state to reset values on the next clock edge. ARVALID_M and RREADY_M drop immediately at that edge.

## Configuration
- L1I_REFILL_PERF_EN defined:
  - refill_cnt increments at each fill_done;
  - stall_cnt increments every cycle state is ADDR or DATA;
  - both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- L1I_REFILL_PERF_EN undefined: refill_cnt and stall_cnt are tied to 0 and no counter flops are built. The ports are present in both builds.

## Test plan
- Zero-wait fill: fill_addr=0x0000_1234, ARREADY/RVALID always 1, RDATA=A0,A1,A2,A3 with RLAST on beat 4 → ARADDR_M=0x0000_1230, ARLEN_M=3; fill_valid at cycles 3–6 with data A0..A3; fill_done at 6; fill_err=0.
- Backpressure: ARREADY low for 3 cycles, then 1-cycle gaps between R beats → ARADDR_M stable while ARVALID_M=1; exactly 4 fill_valid pulses; data in order.
- Held request: fill_req held high through fill_done for 5 more cycles → exactly one AR handshake. Dropping fill_req for 1 cycle and reasserting it → a second burst.
- Error: RRESP=2'b10 on beat 2, or RLAST on beat 3 → all 4 beats still delivered; fill_err=1 with fill_done. The next clean burst gives fill_err=0.
- Reset mid-burst: rst asserted after beat 2 → next cycle state IDLE, fill_wait=0, ARVALID_M=RREADY_M=0, no fill_done.
- With L1I_REFILL_PERF_EN, two zero-wait fills → refill_cnt=2, stall_cnt=10. Without the macro → both read 0.
